conv_window_mac: RTL and testbench
==================================

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning unsigned pixel width.
REQ-002 SHALL have parameter WINDOW_SIZE, default 3, meaning the window edge length (window is WINDOW_SIZE x WINDOW_SIZE).
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, meaning signed two's-complement weight width.
REQ-004 SHALL have parameter BIAS_WIDTH, default 16, meaning signed bias width, in the same fixed-point scale as the products.
REQ-005 SHALL have parameter FRAC_BITS, default 6, meaning the number of fractional bits in weights and bias.
REQ-006 SHALL have port clock_i, input, 1 bit: the single clock. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports slave_tvalid_i (in, 1), slave_tready_o (out, 1), slave_tdata_i (in, DATA_WIDTH*WINDOW_SIZE^2) and slave_tlast_i (in, 1): the window stream. Element (r,c) is at bits [(r*WINDOW_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top row and c=0 the left column.
REQ-009 SHALL have ports master_tvalid_o (out, 1), master_tready_i (in, 1), master_tdata_o (out, DATA_WIDTH) and master_tlast_o (out, 1): the result pixel stream.
REQ-010 SHALL have ports weight_write_i (in, 1), weight_address_i (in, $clog2(WINDOW_SIZE^2+1)) and weight_data_i (in, BIAS_WIDTH): the coefficient load port.

Function
REQ-011 Weight load: a write to address a < WINDOW_SIZE^2 SHALL store weight_data_i[WEIGHT_WIDTH-1:0] as weight (r,c), where a = r*WINDOW_SIZE+c.
REQ-012 Bias load: a write to address WINDOW_SIZE^2 SHALL store the full weight_data_i as the bias.
REQ-013 Writes to higher addresses SHALL be ignored.
REQ-014 A coefficient write SHALL take effect at the clock edge on which it is sampled; a window accepted on that same edge SHALL use the pre-write coefficients.
REQ-015 The result SHALL be y = clamp((bias + sum of w(r,c)*p(r,c) + 2^(FRAC_BITS-1)) >>> FRAC_BITS, 0, 2^DATA_WIDTH-1).
- Pixels are zero-extended; weights and bias are sign-extended.
- >>> is an arithmetic shift.
- The clamp also acts as ReLU.
REQ-016 Accumulation width SHALL be max(DATA_WIDTH+WEIGHT_WIDTH+1+$clog2(WINDOW_SIZE^2), BIAS_WIDTH)+1 bits, so no intermediate overflow is possible.
REQ-017 The pipeline SHALL have exactly 3 register stages:
- S1: per-tap products.
- S2: adder-tree sum plus bias and rounding constant.
- S3: shift and clamp, into the output register.
REQ-018 Latency SHALL be 3 cycles from slave acceptance to master_tvalid_o when master_tready_i stays high.
REQ-019 Handshake: a global advance signal SHALL be defined as advance = !master_tvalid_o || master_tready_i.
- All stages shift only when advance is high.
- slave_tready_o = advance.
REQ-020 With master_tready_i held high, throughput SHALL be one window per cycle with no bubbles.
REQ-021 While master_tvalid_o is high and master_tready_i is low:
- master_tdata_o and master_tlast_o SHALL hold stable.
- No accepted window SHALL be lost or duplicated.
REQ-022 slave_tlast_i SHALL travel with its window and appear on master_tlast_o together with that window's result.
REQ-023 Each stage valid bit SHALL be loaded from the upstream valid only when advance is high, so that gaps in slave_tvalid_i propagate as bubbles.

Reset
REQ-024 While reset_ni is low, these SHALL be 0:
- all stage valid bits
- master_tvalid_o, master_tdata_o, master_tlast_o
- all weights and the bias
REQ-025 Reset asserted mid-stream SHALL discard in-flight windows immediately (asynchronously); no output SHALL appear for them after release.
REQ-026 slave_tready_o SHALL be 0 while reset_ni is low.
REQ-027 slave_tready_o SHALL be 1 in the first cycle after reset_ni is released.

Structure
REQ-028 Package conv_pkg SHALL hold:
- the default values of DATA_WIDTH, WEIGHT_WIDTH, BIAS_WIDTH and FRAC_BITS;
- a function computing the accumulator width per REQ-016.
REQ-029 The adder tree SHALL be a sub-module conv_adder_tree:
- parameters: term count and width;
- combinational signed sum;
- instantiated once, between S1 and S2.
REQ-030 Weights and products SHALL be flat 1-D register arrays, not 3-D arrays.

Verification (WINDOW_SIZE=3, FRAC_BITS=6, DATA_WIDTH=8)
REQ-031 Identity: centre weight 64, others 0, bias 0; centre pixel 200 -> output 200, 3 cycles after acceptance.
REQ-032 Box and saturation:
- All weights 64, all pixels 10 -> output 90.
- All pixels 255 -> output 255 (clamped).
REQ-033 ReLU and rounding:
- Centre weight -64, centre pixel 50 -> output 0.
- Centre weight 32, centre pixel 3 -> output 2 (1.5 rounds up).
- Bias -32 with centre weight 0 -> output 0 (-0.5 rounds to 0).
REQ-034 Back-pressure: stream 8 windows with master_tready_i low for 5 cycles at cycle 4.
- Exactly 8 ordered outputs.
- Data stable while stalled.
- tlast on the 8th output only.
REQ-035 Weight write coincident with acceptance: centre weight changes 64->128 on the same edge as window A (centre 10) is accepted; window B is accepted next cycle with centre 10.
- Window A -> 10.
- Window B -> 20.
REQ-036 Reset mid-stream: assert reset_ni low with 2 windows in flight.
- master_tvalid_o falls to 0 without waiting for a clock edge.
- After release there are no outputs until a new acceptance.
- Weights read back as 0, so a new window produces 0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared parameter defaults and accumulator sizing for conv_window_mac
package conv_pkg;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_BIAS_WIDTH   = 16;
    localparam int DEF_FRAC_BITS    = 6;

    function automatic int acc_width(input int dw, input int ww, input int bw, input int ws);
        int prod_sum;
        prod_sum = dw + ww + 1 + $clog2(ws * ws);
        return ((prod_sum > bw) ? prod_sum : bw) + 1;
    endfunction
endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: combinational signed sum of TERMS flat-packed WIDTH-bit terms
module conv_adder_tree #(
    parameter int TERMS = 9,
    parameter int WIDTH = 22
) (
    input  logic [TERMS*WIDTH-1:0] terms_i,
    output logic signed [WIDTH-1:0] sum_o
);
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < TERMS; i++) sum_o = sum_o + $signed(terms_i[i*WIDTH +: WIDTH]);
    end
endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: 3-stage pipelined window multiply-accumulate with rounding, ReLU and clamp
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WINDOW_SIZE  = 3,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int BIAS_WIDTH   = DEF_BIAS_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS
) (
    input  logic                                      clock_i,
    input  logic                                      reset_ni,
    input  logic                                      slave_tvalid_i,
    output logic                                      slave_tready_o,
    input  logic [DATA_WIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0] slave_tdata_i,
    input  logic                                      slave_tlast_i,
    output logic                                      master_tvalid_o,
    input  logic                                      master_tready_i,
    output logic [DATA_WIDTH-1:0]                     master_tdata_o,
    output logic                                      master_tlast_o,
    input  logic                                      weight_write_i,
    input  logic [$clog2(WINDOW_SIZE*WINDOW_SIZE+1)-1:0] weight_address_i,
    input  logic [BIAS_WIDTH-1:0]                     weight_data_i
);
    localparam int TAPS   = WINDOW_SIZE * WINDOW_SIZE;
    localparam int ACC_W  = acc_width(DATA_WIDTH, WEIGHT_WIDTH, BIAS_WIDTH, WINDOW_SIZE);
    localparam int ADDR_W = $clog2(TAPS + 1);
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'((FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

    logic [TAPS*WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic [BIAS_WIDTH-1:0]        bias_q, bias_d;
    logic [TAPS*ACC_W-1:0]        prod_q, prod_d;
    logic signed [ACC_W-1:0]      tree_sum, sum_q, sum_d, shifted;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic advance;

    conv_adder_tree #(.TERMS(TAPS), .WIDTH(ACC_W)) u_tree (
        .terms_i(prod_q),
        .sum_o  (tree_sum)
    );

    always_comb begin
        advance  = !v3_q || master_tready_i;
        weight_d = weight_q;
        bias_d   = bias_q;
        for (int i = 0; i < TAPS; i++)
            if (weight_write_i && weight_address_i == ADDR_W'(i))
                weight_d[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weight_data_i[WEIGHT_WIDTH-1:0];
        if (weight_write_i && weight_address_i == ADDR_W'(TAPS)) bias_d = weight_data_i;
        // Products use the registered weights, so a same-edge write only affects later windows
        prod_d = prod_q;
        for (int i = 0; i < TAPS; i++)
            if (advance)
                prod_d[i*ACC_W +: ACC_W] =
                    {{(ACC_W-DATA_WIDTH){1'b0}}, slave_tdata_i[i*DATA_WIDTH +: DATA_WIDTH]} *
                    {{(ACC_W-WEIGHT_WIDTH){weight_q[(i+1)*WEIGHT_WIDTH-1]}}, weight_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
        v1_d    = advance ? slave_tvalid_i : v1_q;
        last1_d = advance ? slave_tlast_i : last1_q;
        v2_d    = advance ? v1_q : v2_q;
        last2_d = advance ? last1_q : last2_q;
        sum_d   = advance ? tree_sum + {{(ACC_W-BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q} + ROUND : sum_q;
        shifted = sum_q >>> FRAC_BITS;
        v3_d    = advance ? v2_q : v3_q;
        last3_d = advance ? last2_q : last3_q;
        data_d  = !advance ? data_q :
                  (shifted < 0) ? '0 :
                  (shifted > PIX_MAX) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            weight_q <= '0;
            bias_q   <= '0;
            prod_q   <= '0;
            sum_q    <= '0;
            data_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
            last3_q  <= 1'b0;
        end else begin
            weight_q <= weight_d;
            bias_q   <= bias_d;
            prod_q   <= prod_d;
            sum_q    <= sum_d;
            data_q   <= data_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            last1_q  <= last1_d;
            last2_q  <= last2_d;
            last3_q  <= last3_d;
        end
    end

    assign slave_tready_o  = advance && reset_ni;
    assign master_tvalid_o = v3_q;
    assign master_tdata_o  = data_q;
    assign master_tlast_o  = last3_q;
endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: randomized self-checking bench against an integer reference model
module tb_conv_window_mac;
    localparam int WW = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [71:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        w_write = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [15:0] w_data = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int w_m[9];
    int bias_m = 0;
    logic [8:0] got_q[$];
    int         got_cyc[$];
    logic [8:0] exp_q[$];

    conv_window_mac #(.DATA_WIDTH(8), .WINDOW_SIZE(3), .WEIGHT_WIDTH(WW), .BIAS_WIDTH(16), .FRAC_BITS(6)) dut (
        .clock_i         (clk),
        .reset_ni        (rst_n),
        .slave_tvalid_i  (s_valid),
        .slave_tready_o  (s_ready),
        .slave_tdata_i   (s_data),
        .slave_tlast_i   (s_last),
        .master_tvalid_o (m_valid),
        .master_tready_i (m_ready),
        .master_tdata_o  (m_data),
        .master_tlast_o  (m_last),
        .weight_write_i  (w_write),
        .weight_address_i(w_addr),
        .weight_data_i   (w_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && m_valid && m_ready) begin
            got_q.push_back({m_last, m_data});
            got_cyc.push_back(cyc);
        end

    function automatic logic [7:0] model(input logic [71:0] px);
        longint acc;
        acc = longint'(bias_m) + 32;
        for (int i = 0; i < 9; i++) acc += longint'(w_m[i]) * longint'(px[i*8 +: 8]);
        acc = acc >>> 6;
        return (acc < 0) ? 8'd0 : (acc > 255) ? 8'd255 : 8'(acc);
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    function automatic logic [71:0] centre(input logic [7:0] c);
        logic [71:0] w;
        w = rand_win();
        w[32 +: 8] = c;
        return w;
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wr(input int a, input int v);
        logic [15:0] d;
        d = 16'(v);
        w_write = 1'b1;
        w_addr  = 4'(a);
        w_data  = d;
        @(posedge clk); #1;
        w_write = 1'b0;
        if (a < 9) w_m[a] = int'($signed(d[WW-1:0]));
        else if (a == 9) bias_m = int'($signed(d));
    endtask

    task automatic send(input logic [71:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send: window not accepted within 100 cycles");
        end else exp_q.push_back({last, model(d)});
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'd0) begin errors++; $display("FAIL reset_tdata got=%0d exp=0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_last); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", s_ready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b exp=1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        bit ok;
        int a;
        wr(4, 64);
        send(centre(8'd200), 1'b0);
        a = acc_cyc;
        wait_out(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL identity: no output within budget");
        end else begin
            checks++; if (got_q[0] !== 9'd200) begin errors++; $display("FAIL identity got=%0d exp=200", got_q[0]); end
            checks++; if (got_cyc[0] !== a + 3) begin errors++; $display("FAIL latency got=%0d exp=3", got_cyc[0] - a); end
        end
        clear_q();
    endtask

    task automatic test_box();
        bit ok;
        for (int a = 0; a < 9; a++) wr(a, 64);
        send(fill(8'd10), 1'b0);
        send(fill(8'd255), 1'b0);
        wait_out(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL box: outputs missing got=%0d exp=2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 9'd90) begin errors++; $display("FAIL box10 got=%0d exp=90", got_q[0]); end
            checks++; if (got_q[1] !== 9'd255) begin errors++; $display("FAIL box255 got=%0d exp=255", got_q[1]); end
        end
        clear_q();
    endtask

    task automatic test_relu_round();
        bit ok;
        logic [8:0] exp_v[3] = '{9'd0, 9'd2, 9'd0};
        for (int a = 0; a < 10; a++) wr(a, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin wr(4, -64); send(centre(8'd50), 1'b0); end
            if (k == 1) begin wr(4, 32); send(centre(8'd3), 1'b0); end
            if (k == 2) begin wr(4, 0); wr(9, -32); send(centre(8'($urandom_range(0, 255))), 1'b0); end
            wait_out(1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL relu_round[%0d]: no output", k);
            end else if (got_q[0] !== exp_v[k]) begin
                errors++;
                $display("FAIL relu_round[%0d] got=%0d exp=%0d", k, got_q[0], exp_v[k]);
            end
            clear_q();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int a = 0; a < 9; a++) wr(a, int'($urandom_range(0, 255)) - 128);
        wr(9, int'($urandom_range(0, 4095)) - 2048);
        wr(10, int'($urandom_range(0, 65535)));
        wr(15, int'($urandom_range(0, 65535)));
        for (int i = 0; i < 20; i++) send(rand_win(), i == 19);
        wait_out(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b: outputs got=%0d exp=20", got_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (got_cyc[19] - got_cyc[0] !== 19) begin
                errors++;
                $display("FAIL b2b_throughput span got=%0d exp=19", got_cyc[19] - got_cyc[0]);
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [8:0] held;
        bit have;
        have = 1'b0;
        held = '0;
        fork
            for (int i = 0; i < 8; i++) send(rand_win(), i == 7);
            begin
                repeat (4) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (!m_valid) begin
                        errors++;
                        $display("FAIL stall_valid got=0 exp=1");
                    end else if (!have) begin
                        held = {m_last, m_data};
                        have = 1'b1;
                    end else if ({m_last, m_data} !== held) begin
                        errors++;
                        $display("FAIL stall_stable got=%0h exp=%0h", {m_last, m_data}, held);
                    end
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_out(8, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=8", got_q.size());
        end
        if (ok && exp_q.size() == 8)
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]);
                end
            end
        clear_q();
    endtask

    task automatic test_coincident_write();
        bit ok;
        for (int a = 0; a < 10; a++) wr(a, 0);
        wr(4, 64);
        s_data  = centre(8'd10);
        s_valid = 1'b1;
        w_write = 1'b1;
        w_addr  = 4'd4;
        w_data  = 16'd128;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL coincident_ready got=%b exp=1", s_ready); end
        @(posedge clk); #1;
        w_write = 1'b0;
        w_m[4]  = 128;
        s_data  = centre(8'd10);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_out(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coincident: outputs got=%0d exp=2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 9'd10) begin errors++; $display("FAIL coincident_A got=%0d exp=10", got_q[0]); end
            checks++; if (got_q[1] !== 9'd20) begin errors++; $display("FAIL coincident_B got=%0d exp=20", got_q[1]); end
        end
        clear_q();
    endtask

    task automatic test_reset_midstream();
        bit ok;
        m_ready = 1'b0;
        send(rand_win(), 1'b0);
        send(rand_win(), 1'b1);
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midstream_inflight got=%b exp=1", m_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL async_tvalid got=%b exp=0", m_valid); end
        checks++; if ({m_last, m_data} !== 9'd0) begin errors++; $display("FAIL async_tdata got=%0h exp=0", {m_last, m_data}); end
        clear_q();
        for (int i = 0; i < 9; i++) w_m[i] = 0;
        bias_m = 0;
        @(posedge clk); #2;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ghost_outputs got=%0d exp=0", got_q.size()); end
        send(fill(8'd255), 1'b0);
        wait_out(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset: no output");
        end else if (got_q[0] !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_zero got=%0d exp=0", got_q[0]);
        end
        clear_q();
    endtask

    initial begin
        for (int i = 0; i < 9; i++) w_m[i] = 0;
        test_reset();
        test_identity();
        test_box();
        test_relu_round();
        test_back_to_back();
        test_backpressure();
        test_coincident_write();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
